// File: rtl/maxpool_window_ctrl_if.sv
// Signal bundle between the 2x2 max-pool sequencer and its environment.
// master = sequencer; slave = control, source memory, max unit and destination buffer.
// Reads return data one cycle after rd_en; the max unit returns results at its own pace.
interface maxpool_window_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
);
  logic              start;
  logic [DIM_W-1:0]  in_width;
  logic [DIM_W-1:0]  in_height;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] win_d0;
  logic [DATA_W-1:0] win_d1;
  logic [DATA_W-1:0] win_d2;
  logic [DATA_W-1:0] win_d3;
  logic              win_valid;
  logic [DATA_W-1:0] max_in;
  logic              max_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, in_width, in_height, src_base, dst_base, rd_data, max_in, max_valid,
    output rd_en, rd_addr, win_d0, win_d1, win_d2, win_d3, win_valid,
           wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    output start, in_width, in_height, src_base, dst_base, rd_data, max_in, max_valid,
    input  rd_en, rd_addr, win_d0, win_d1, win_d2, win_d3, win_valid,
           wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/maxpool_window_ctrl.sv
// 2x2/stride-2 max-pool sequencer: 4 reads per window, gathers window, writes max results.
// Latency: first window valid 6 cycles after start; done 4*N+6 cycles after start (2 if N==0).
// No backpressure: reads stream one per cycle; results are counted, not timed. Option: MAXPOOL_RELU_EN.
module maxpool_window_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input logic                   clk,
  input logic                   reset,
  maxpool_window_ctrl_if.master bus
);
  localparam int                CNT_W = 2 * DIM_W;
  localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO_A = ADDR_W'(2);
  localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;
  state_t r_state, w_next;

  logic [DIM_W-1:0]  r_width, r_height, r_col, r_row;
  logic [1:0]        r_ph;
  logic [ADDR_W-1:0] r_row_addr, r_win_addr;
  logic              r_rd_vld;
  logic [1:0]        r_rd_ph;
  logic [DATA_W-1:0] r_stage0, r_stage1, r_stage2;
  logic [DATA_W-1:0] r_win_d0, r_win_d1, r_win_d2, r_win_d3;
  logic              r_win_vld;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [ADDR_W-1:0] r_wr_ptr, r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_en;

  logic              w_start_acc, w_rd_en, w_busy, w_done, w_degen, w_last_col, w_last_row;
  logic [DIM_W-1:0]  w_ow, w_oh;
  logic [CNT_W-1:0]  w_total;
  logic [ADDR_W-1:0] w_wa, w_w2, w_rd_addr;
  logic [DATA_W-1:0] w_wr_data;

  // Output geometry: an odd trailing column/row is simply dropped by the floor.
  assign w_ow        = r_width >> 1;
  assign w_oh        = r_height >> 1;
  assign w_degen     = (w_ow == '0) || (w_oh == '0);
  assign w_total     = CNT_W'(w_ow) * CNT_W'(w_oh);
  assign w_wa        = ADDR_W'(r_width);
  assign w_w2        = w_wa + w_wa;
  assign w_last_col  = (r_col == w_ow - ONE_D);
  assign w_last_row  = (r_row == w_oh - ONE_D);
  assign w_start_acc = (r_state == S_IDLE) && bus.start;

`ifdef MAXPOOL_RELU_EN
  // Fused ReLU: negative maxima are clamped to zero before the write.
  assign w_wr_data = bus.max_in[DATA_W-1] ? '0 : bus.max_in;
`else
  assign w_wr_data = bus.max_in;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus the state-decoded strobes (rd_en, busy, done).
  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_READ;
      S_READ: begin
        w_busy = 1'b1;
        if (w_degen) begin
          w_next = S_FIN;
        end else begin
          w_rd_en = 1'b1;
          if ((r_ph == 2'd3) && w_last_col && w_last_row) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (r_wr_cnt == w_total) w_next = S_FIN;
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Read address: window origin plus the tap offset for the current phase.
  always_comb begin
    w_rd_addr = '0;
    if (w_rd_en) begin
      case (r_ph)
        2'd0:    w_rd_addr = r_win_addr;
        2'd1:    w_rd_addr = r_win_addr + ONE_A;
        2'd2:    w_rd_addr = r_win_addr + w_wa;
        default: w_rd_addr = r_win_addr + w_wa + ONE_A;
      endcase
    end
  end

  // Window walker: latch geometry at start, step phase/column/row as reads issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_width <= '0; r_height <= '0; r_col <= '0; r_row <= '0; r_ph <= '0;
      r_row_addr <= '0; r_win_addr <= '0;
    end else if (w_start_acc) begin
      r_width    <= bus.in_width;
      r_height   <= bus.in_height;
      r_col      <= '0;
      r_row      <= '0;
      r_ph       <= '0;
      r_row_addr <= bus.src_base;
      r_win_addr <= bus.src_base;
    end else if (w_rd_en) begin
      r_ph <= r_ph + 2'd1;
      if (r_ph == 2'd3) begin
        if (w_last_col) begin
          r_col      <= '0;
          r_row      <= r_row + ONE_D;
          r_row_addr <= r_row_addr + w_w2;
          r_win_addr <= r_row_addr + w_w2;
        end else begin
          r_col      <= r_col + ONE_D;
          r_win_addr <= r_win_addr + TWO_A;
        end
      end
    end
  end

  // Stage returning read data; the fourth word releases the whole window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld <= 1'b0; r_rd_ph <= '0; r_win_vld <= 1'b0;
      r_stage0 <= '0; r_stage1 <= '0; r_stage2 <= '0;
      r_win_d0 <= '0; r_win_d1 <= '0; r_win_d2 <= '0; r_win_d3 <= '0;
    end else begin
      r_rd_vld  <= w_rd_en;
      r_rd_ph   <= r_ph;
      r_win_vld <= 1'b0;
      if (r_rd_vld) begin
        case (r_rd_ph)
          2'd0: r_stage0 <= bus.rd_data;
          2'd1: r_stage1 <= bus.rd_data;
          2'd2: r_stage2 <= bus.rd_data;
          default: begin
            r_win_d0  <= r_stage0;
            r_win_d1  <= r_stage1;
            r_win_d2  <= r_stage2;
            r_win_d3  <= bus.rd_data;
            r_win_vld <= 1'b1;
          end
        endcase
      end
    end
  end

  // Register one destination write per returned result; the count ends the pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en <= 1'b0; r_wr_addr <= '0; r_wr_data <= '0; r_wr_ptr <= '0; r_wr_cnt <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start_acc) begin
        r_wr_ptr <= bus.dst_base;
        r_wr_cnt <= '0;
      end else if (w_busy && bus.max_valid) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_wr_ptr;
        r_wr_data <= w_wr_data;
        r_wr_ptr  <= r_wr_ptr + ONE_A;
        r_wr_cnt  <= r_wr_cnt + ONE_C;
      end
    end
  end

  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = w_rd_addr;
  assign bus.win_d0    = r_win_d0;
  assign bus.win_d1    = r_win_d1;
  assign bus.win_d2    = r_win_d2;
  assign bus.win_d3    = r_win_d3;
  assign bus.win_valid = r_win_vld;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Self-checking bench for maxpool_window_ctrl: table of passes, hand-written corner sequences, random passes.
// Source memory and a 2-cycle max unit are modelled here; expectations come from a loop-level window model.
// No backpressure in the environment; every wait is bounded by a cycle limit.
module tb_maxpool_window_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 8;

`ifdef MAXPOOL_RELU_EN
  localparam logic [31:0] NEG_EXP = 32'd0;
`else
  localparam logic [31:0] NEG_EXP = 32'hFFFF_FFFE;
`endif

  typedef struct { int n; logic [15:0] a; } rd_ev_t;
  typedef struct { int n; logic [31:0] d0, d1, d2, d3; } win_ev_t;
  typedef struct { int n; logic [15:0] a; logic [31:0] d; } wr_ev_t;
  typedef struct {
    string nm; int w; int h; int src; int dst; int nwr; int dn; logic chk_wd; logic [31:0] wd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  maxpool_window_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();
  maxpool_window_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  logic [31:0] mem [0:65535];
  int n_chk = 0;
  int n_fail = 0;

  rd_ev_t  obs_rd[$],  exp_rd[$];
  win_ev_t obs_win[$], exp_win[$];
  wr_ev_t  obs_wr[$],  exp_wr[$];
  int      obs_done[$];
  int      busy_cnt;

  // Source memory: data for a read appears in the following cycle.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  function automatic logic [31:0] smax(input logic [31:0] a, input logic [31:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Downstream max unit: two register stages from win_valid to max_valid.
  logic        mu_v1;
  logic [31:0] mu_m1;
  always @(posedge clk) begin
    if (reset) begin
      mu_v1 <= 1'b0; mu_m1 <= '0; bus.max_valid <= 1'b0; bus.max_in <= '0;
    end else begin
      mu_v1         <= bus.win_valid;
      mu_m1         <= smax(smax(bus.win_d0, bus.win_d1), smax(bus.win_d2, bus.win_d3));
      bus.max_valid <= mu_v1;
      bus.max_in    <= mu_m1;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected event lists for one pass, derived window by window from the pooling rule.
  task automatic build_model(input int w, input int h, input int src, input int dst, input int rst_cyc);
    int ow, oh, k;
    logic [15:0] p;
    logic [15:0] a [4];
    logic [31:0] mx;
    rd_ev_t  re;
    win_ev_t we;
    wr_ev_t  wre;
    exp_rd.delete(); exp_win.delete(); exp_wr.delete();
    ow = w / 2;
    oh = h / 2;
    for (int r = 0; r < oh; r++) begin
      for (int c = 0; c < ow; c++) begin
        k = r * ow + c;
        p = 16'(src + 2 * r * w + 2 * c);
        a[0] = p; a[1] = p + 16'd1; a[2] = p + 16'(w); a[3] = p + 16'(w) + 16'd1;
        for (int j = 0; j < 4; j++) begin
          re.n = 1 + 4 * k + j; re.a = a[j];
          exp_rd.push_back(re);
        end
        we.n = 6 + 4 * k;
        we.d0 = mem[a[0]]; we.d1 = mem[a[1]]; we.d2 = mem[a[2]]; we.d3 = mem[a[3]];
        exp_win.push_back(we);
        mx = smax(smax(we.d0, we.d1), smax(we.d2, we.d3));
`ifdef MAXPOOL_RELU_EN
        if (mx[31]) mx = 32'd0;
`endif
        wre.n = 9 + 4 * k; wre.a = 16'(dst + k); wre.d = mx;
        exp_wr.push_back(wre);
      end
    end
    if (rst_cyc >= 0) begin
      while (exp_rd.size() > 0 && exp_rd[$].n > rst_cyc) void'(exp_rd.pop_back());
      while (exp_win.size() > 0 && exp_win[$].n > rst_cyc) void'(exp_win.pop_back());
      while (exp_wr.size() > 0 && exp_wr[$].n > rst_cyc) void'(exp_wr.pop_back());
    end
  endtask

  // One pass: start in cycle 0, optional extra start (ignored by DUT) and optional mid-pass reset.
  task automatic run_pass(input string nm, input int w, input int h, input int src, input int dst,
                          input int extra_start, input int rst_cyc, input int exp_nwr, input int exp_done);
    int limit;
    rd_ev_t re; win_ev_t we; wr_ev_t wre;
    build_model(w, h, src, dst, rst_cyc);
    obs_rd.delete(); obs_win.delete(); obs_wr.delete(); obs_done.delete();
    busy_cnt = 0;
    limit = (rst_cyc >= 0) ? rst_cyc + 30 : exp_done + 20;
    @(posedge clk); #1;
    for (int i = 0; i < limit; i++) begin
      if (i == 0) begin
        bus.in_width = 8'(w); bus.in_height = 8'(h);
        bus.src_base = 16'(src); bus.dst_base = 16'(dst); bus.start = 1'b1;
      end else if (i == extra_start) begin
        bus.in_width = 8'd2; bus.in_height = 8'd2;
        bus.src_base = 16'h0030; bus.dst_base = 16'h0F00; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      reset = (i == rst_cyc);
      @(negedge clk);
      if (bus.rd_en) begin re.n = i; re.a = bus.rd_addr; obs_rd.push_back(re); end
      if (bus.win_valid) begin
        we.n = i; we.d0 = bus.win_d0; we.d1 = bus.win_d1; we.d2 = bus.win_d2; we.d3 = bus.win_d3;
        obs_win.push_back(we);
      end
      if (bus.wr_en) begin wre.n = i; wre.a = bus.wr_addr; wre.d = bus.wr_data; obs_wr.push_back(wre); end
      if (bus.done) obs_done.push_back(i);
      if (bus.busy) busy_cnt++;
      if (rst_cyc >= 0 && i == rst_cyc + 1) begin
        check({nm, " post-reset rd_en"}, 64'(bus.rd_en), 64'd0);
        check({nm, " post-reset win_valid"}, 64'(bus.win_valid), 64'd0);
        check({nm, " post-reset wr_en"}, 64'(bus.wr_en), 64'd0);
        check({nm, " post-reset busy"}, 64'(bus.busy), 64'd0);
        check({nm, " post-reset buses"}, 64'(|{bus.rd_addr, bus.win_d0, bus.win_d1, bus.win_d2,
              bus.win_d3, bus.wr_addr, bus.wr_data, bus.done}), 64'd0);
      end
      if (obs_done.size() > 0 && i >= obs_done[0] + 3) break;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    reset = 1'b0;

    check({nm, " done pulses"}, 64'(obs_done.size()), (rst_cyc >= 0) ? 64'd0 : 64'd1);
    if (obs_done.size() > 0 && exp_done >= 0) check({nm, " done cycle"}, 64'(obs_done[0]), 64'(exp_done));
    check({nm, " busy cycles"}, 64'(busy_cnt), (rst_cyc >= 0) ? 64'(rst_cyc) : 64'(exp_done - 1));
    check({nm, " write count"}, 64'(obs_wr.size()), 64'(exp_nwr));
    check({nm, " read count"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
    check({nm, " window count"}, 64'(obs_win.size()), 64'(exp_win.size()));
    for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++) begin
      check($sformatf("%s rd%0d addr", nm, i), 64'(obs_rd[i].a), 64'(exp_rd[i].a));
      check($sformatf("%s rd%0d cycle", nm, i), 64'(obs_rd[i].n), 64'(exp_rd[i].n));
    end
    for (int i = 0; i < obs_win.size() && i < exp_win.size(); i++) begin
      check($sformatf("%s win%0d cycle", nm, i), 64'(obs_win[i].n), 64'(exp_win[i].n));
      check($sformatf("%s win%0d data", nm, i),
            {obs_win[i].d0, obs_win[i].d1} ^ {obs_win[i].d2, obs_win[i].d3} ^ 64'(obs_win[i].d0 == exp_win[i].d0 &&
             obs_win[i].d1 == exp_win[i].d1 && obs_win[i].d2 == exp_win[i].d2 && obs_win[i].d3 == exp_win[i].d3),
            {exp_win[i].d0, exp_win[i].d1} ^ {exp_win[i].d2, exp_win[i].d3} ^ 64'd1);
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      check($sformatf("%s wr%0d addr", nm, i), 64'(obs_wr[i].a), 64'(exp_wr[i].a));
      check($sformatf("%s wr%0d data", nm, i), 64'(obs_wr[i].d), 64'(exp_wr[i].d));
      check($sformatf("%s wr%0d cycle", nm, i), 64'(obs_wr[i].n), 64'(exp_wr[i].n));
    end
  endtask

  vec_t tbl [9];

  initial begin
    int w, h, n;
    tbl[0] = '{"plan2x2", 2, 2, 'h10,   'h80,   1, 10, 1'b1, 32'd9};
    tbl[1] = '{"plan4x4", 4, 4, 'h0,    'h200,  4, 22, 1'b1, 32'd5};
    tbl[2] = '{"map5x3",  5, 3, 'h40,   'h300,  2, 14, 1'b0, 32'd0};
    tbl[3] = '{"width1",  1, 4, 'h50,   'h400,  0, 2,  1'b0, 32'd0};
    tbl[4] = '{"height1", 4, 1, 'h50,   'h400,  0, 2,  1'b0, 32'd0};
    tbl[5] = '{"negwin",  2, 2, 'h20,   'h90,   1, 10, 1'b1, NEG_EXP};
    tbl[6] = '{"wrap3x3", 3, 3, 'hFFFE, 'hFFFF, 1, 10, 1'b0, 32'd0};
    tbl[7] = '{"map6x4",  6, 4, 'h100,  'h500,  6, 30, 1'b0, 32'd0};
    tbl[8] = '{"map7x5",  7, 5, 'h200,  'h600,  6, 30, 1'b0, 32'd0};

    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i);
    mem['h10] = 32'd5;  mem['h11] = -32'sd3; mem['h12] = 32'd9;  mem['h13] = 32'd2;
    mem['h20] = -32'sd7; mem['h21] = -32'sd2; mem['h22] = -32'sd9; mem['h23] = -32'sd4;

    reset = 1'b1;
    bus.start = 1'b0; bus.in_width = '0; bus.in_height = '0; bus.src_base = '0; bus.dst_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rd_en", 64'(bus.rd_en), 64'd0);
    check("reset rd_addr", 64'(bus.rd_addr), 64'd0);
    check("reset win_valid", 64'(bus.win_valid), 64'd0);
    check("reset win_d", 64'(|{bus.win_d0, bus.win_d1, bus.win_d2, bus.win_d3}), 64'd0);
    check("reset wr_en", 64'(bus.wr_en), 64'd0);
    check("reset wr_addr", 64'(bus.wr_addr), 64'd0);
    check("reset wr_data", 64'(bus.wr_data), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_pass(tbl[i].nm, tbl[i].w, tbl[i].h, tbl[i].src, tbl[i].dst, -1, -1, tbl[i].nwr, tbl[i].dn);
      if (tbl[i].chk_wd) begin
        check({tbl[i].nm, " first write present"}, 64'(obs_wr.size() > 0), 64'd1);
        if (obs_wr.size() > 0) check({tbl[i].nm, " first write data"}, 64'(obs_wr[0].d), 64'(tbl[i].wd));
      end
    end

    // start pulsed mid-pass with different geometry must be ignored
    run_pass("ignstart", 4, 4, 'h0, 'h200, 3, -1, 4, 22);
    // reset in cycle 12 aborts the pass; the next pass must be complete
    run_pass("rstmid", 4, 4, 'h0, 'h200, -1, 12, 1, -1);
    run_pass("afterrst", 4, 4, 'h0, 'h200, -1, -1, 4, 22);

    for (int t = 0; t < 12; t++) begin
      w = $urandom_range(0, 9);
      h = $urandom_range(0, 9);
      n = (w / 2) * (h / 2);
      run_pass($sformatf("rand%0d", t), w, h, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               -1, -1, n, (n > 0) ? 4 * n + 6 : 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
